// File: rtl/or1200_operandmuxes_param.sv
// ---------------------------------------------------------------------------
// or1200_operandmuxes_param
//
// Parametrised ID->EX operand multiplexers with freeze-save hold logic.
// Each of NUM_OPS channels selects among its register-file read data, the
// shared sign-extended immediate and NUM_FWD forwarding buses. The selected
// value is registered into the EX stage. When the ID stage freezes, the
// value present at freeze onset is captured once and held until the freeze
// releases. This keeps the EX operand stable while upstream buses move.
//
// Select encoding per channel (s = sel slice):
//   0             : rf_data of this channel
//   1             : simm
//   2..NUM_FWD+1  : fwd_data bus s-2 (0 = EX, 1 = WB, higher = later stages)
//   > NUM_FWD+1   : rf_data of this channel; also raises sticky sel_err
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   id_freeze  ID stage frozen
//   ex_freeze  EX stage frozen (holds all channel state)
//   rf_data    NUM_OPS*DW register-file read data, channel i at [i*DW +: DW]
//   simm       DW sign-extended immediate, shared by all channels
//   fwd_data   NUM_FWD*DW forwarding buses, bus k at [k*DW +: DW]
//   sel        NUM_OPS*SELW selects, channel i at [i*SELW +: SELW]
//   muxed      NUM_OPS*DW combinational mux result per channel
//   operand    NUM_OPS*DW registered EX-stage operand per channel
//   saved      NUM_OPS freeze-save flag per channel
//   sel_err    NUM_OPS sticky out-of-range select flag per channel
// ---------------------------------------------------------------------------
module or1200_operandmuxes_param #(
  parameter  int DW      = 32,
  parameter  int NUM_OPS = 2,
  parameter  int NUM_FWD = 2,
  localparam int SELW    = $clog2(NUM_FWD + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_freeze,
  input  logic                    ex_freeze,
  input  logic [NUM_OPS*DW-1:0]   rf_data,
  input  logic [DW-1:0]           simm,
  input  logic [NUM_FWD*DW-1:0]   fwd_data,
  input  logic [NUM_OPS*SELW-1:0] sel,
  output logic [NUM_OPS*DW-1:0]   muxed,
  output logic [NUM_OPS*DW-1:0]   operand,
  output logic [NUM_OPS-1:0]      saved,
  output logic [NUM_OPS-1:0]      sel_err
);

  // Highest select value that addresses a real source.
  localparam logic [SELW:0] SEL_MAX = (SELW + 1)'(NUM_FWD + 1);

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_ch
    logic [SELW-1:0] s;
    logic [DW-1:0]   mux_val;
    logic [DW-1:0]   op_q;
    logic            saved_q;
    logic            err_q;
    logic            sel_oob;

    assign s = sel[i*SELW +: SELW];

    // Widened by one bit so the compare stays meaningful when every code
    // of the select field maps to a real source.
    assign sel_oob = {1'b0, s} > SEL_MAX;

    always_comb begin
      // NOTE: default assigned first so every path drives mux_val; without it
      // an unmatched select would infer a latch. Out-of-range falls back here.
      mux_val = rf_data[i*DW +: DW];
      if (s == SELW'(1)) mux_val = simm;
      for (int k = 0; k < NUM_FWD; k++) begin
        if (s == SELW'(k + 2)) mux_val = fwd_data[k*DW +: DW];
      end
    end

    // Priority: EX freeze holds everything; otherwise an unsaved channel
    // loads (and latches the save flag on ID-freeze onset); a saved channel
    // only clears its flag once ID unfreezes, so the held value is used for
    // exactly the frozen span and the next edge resumes normal flow.
    // While saved, muxed and sel are ignored, so a corrupt select on a held
    // channel cannot disturb operand or sel_err.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        // NOTE: non-blocking assignments for all state so every channel
        // samples pre-edge values regardless of evaluation order.
        op_q    <= '0;
        saved_q <= 1'b0;
        err_q   <= 1'b0;
      end else if (!ex_freeze) begin
        if (!saved_q) begin
          op_q <= mux_val;
          if (id_freeze) saved_q <= 1'b1;
          if (sel_oob)   err_q   <= 1'b1;
        end else if (!id_freeze) begin
          saved_q <= 1'b0;
        end
      end
    end

    assign muxed[i*DW +: DW]   = mux_val;
    assign operand[i*DW +: DW] = op_q;
    assign saved[i]            = saved_q;
    assign sel_err[i]          = err_q;
  end

endmodule
